// File: rtl/ch_packer_pkg.sv
// Shared defaults and state encoding for the channel packer.
package ch_packer_pkg;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_RATIO  = 4;
    localparam int unsigned CNT_W      = $clog2(DEF_RATIO) + 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/ch_packer.sv
// Packs RATIO narrow beats into one wide word, beat 0 in the LSBs.
// Optional CH_PACKER_FLUSH_EN adds io_flush / io_deq_count for partial words.
module ch_packer
    import ch_packer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RATIO  = DEF_RATIO
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_enq_valid,
    input  logic [DATA_W-1:0]        io_enq_data,
    output logic                     io_enq_ready,
    output logic                     io_deq_valid,
    output logic [DATA_W*RATIO-1:0]  io_deq_data,
    input  logic                     io_deq_ready
`ifdef CH_PACKER_FLUSH_EN
    ,
    input  logic                     io_flush,
    output logic [$clog2(RATIO):0]   io_deq_count
`endif
);

    localparam int unsigned CW = $clog2(RATIO) + 1;

    logic [CW-1:0] count;
    logic [CW-1:0] wr_idx;
    logic          full;
    logic          enq_fire;
    logic          deq_fire;
    state_t        state;

`ifdef CH_PACKER_FLUSH_EN
    // A flushed partial word is held in FULL with count below RATIO.
    logic flushed;
    assign full         = (count == CW'(RATIO)) || flushed;
    assign io_deq_count = count;
`else
    assign full = (count == CW'(RATIO));
`endif

    always_comb begin
        state = FILL;
        if (full) begin
            state = FULL;
        end
    end

    assign io_enq_ready = (state == FILL) || io_deq_ready;
    assign io_deq_valid = (state == FULL);
    assign enq_fire     = io_enq_valid && io_enq_ready;
    assign deq_fire     = io_deq_valid && io_deq_ready;
    // An enq alongside a deq starts the next word in lane 0.
    assign wr_idx       = deq_fire ? '0 : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (deq_fire) begin
            count <= enq_fire ? CW'(1) : '0;
        end else if (enq_fire) begin
            count <= count + CW'(1);
        end
    end

`ifdef CH_PACKER_FLUSH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            flushed <= 1'b0;
        end else if (deq_fire) begin
            flushed <= 1'b0;
        end else if ((state == FILL) && io_flush && ((count != '0) || enq_fire)) begin
            flushed <= 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < int'(RATIO); i++) begin : g_lane
        logic [DATA_W-1:0] lane;

        // Lanes are cleared on every deq so unwritten lanes read as zero.
        always_ff @(posedge clk) begin
            if (reset) begin
                lane <= '0;
            end else if (enq_fire && (wr_idx == CW'(i))) begin
                lane <= io_enq_data;
            end else if (deq_fire) begin
                lane <= '0;
            end
        end

        assign io_deq_data[i*DATA_W +: DATA_W] = lane;
    end

endmodule

// File: tb/tb_ch_packer.sv
// Randomised and directed bench for ch_packer against a queue-based word model.
module tb_ch_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_enq_valid = 1'b0;
    logic [3:0]  io_enq_data = '0;
    logic        io_enq_ready;
    logic        io_deq_valid;
    logic [15:0] io_deq_data;
    logic        io_deq_ready = 1'b0;
`ifdef CH_PACKER_FLUSH_EN
    logic        io_flush = 1'b0;
    logic [2:0]  io_deq_count;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    // Reference model: beats of the word being collected, plus the word on offer.
    logic [3:0]  beats[$];
    logic        held_valid = 1'b0;
    logic [15:0] held_word = '0;
    int unsigned held_cnt = 0;
    logic [15:0] got_words[$];
    int unsigned got_cyc[$];

    always #5 clk = ~clk;

    ch_packer dut (
        .clk          (clk),
        .reset        (reset),
        .io_enq_valid (io_enq_valid),
        .io_enq_data  (io_enq_data),
        .io_enq_ready (io_enq_ready),
        .io_deq_valid (io_deq_valid),
        .io_deq_data  (io_deq_data),
        .io_deq_ready (io_deq_ready)
`ifdef CH_PACKER_FLUSH_EN
        ,
        .io_flush     (io_flush),
        .io_deq_count (io_deq_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pack(input logic [3:0] b[$]);
        logic [15:0] w = '0;
        for (int i = 0; i < b.size(); i++) begin
            w = w | (16'(b[i]) << (4 * i));
        end
        return w;
    endfunction

    // One cycle: drive, check outputs against the model, clock, advance the model.
    task automatic step(input logic v, input logic [3:0] d, input logic dr);
        logic exp_ready;
        logic enq_f;
        logic deq_f;
        logic fl;
        io_enq_valid = v;
        io_enq_data  = d;
        io_deq_ready = dr;
        fl = 1'b0;
`ifdef CH_PACKER_FLUSH_EN
        fl = io_flush;
`endif
        #1;
        exp_ready = !held_valid || dr;
        check("enq_ready", 32'(io_enq_ready), 32'(exp_ready));
        check("deq_valid", 32'(io_deq_valid), 32'(held_valid));
        check("deq_data", 32'(io_deq_data), 32'(held_valid ? held_word : pack(beats)));
`ifdef CH_PACKER_FLUSH_EN
        if (held_valid) check("deq_count", 32'(io_deq_count), 32'(held_cnt));
`endif
        if (io_deq_valid && dr) begin
            got_words.push_back(io_deq_data);
            got_cyc.push_back(cyc);
        end
        enq_f = v && exp_ready;
        deq_f = held_valid && dr;
        @(posedge clk);
        if (deq_f) held_valid = 1'b0;
        if (enq_f) beats.push_back(d);
        if (beats.size() == 4 || (fl && !held_valid && !deq_f && beats.size() > 0)) begin
            held_word  = pack(beats);
            held_cnt   = beats.size();
            held_valid = 1'b1;
            beats.delete();
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_enq_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(io_deq_valid), 32'd0);
        check("rst_data", 32'(io_deq_data), 32'd0);
        check("rst_ready", 32'(io_enq_ready), 32'd1);
        reset = 1'b0;
        beats.delete();
        held_valid = 1'b0;
        got_words.delete();
        got_cyc.delete();
    endtask

    initial begin
        int unsigned start;
        @(negedge clk);
        do_reset();

        // Basic four-beat pack.
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b1);
        check("basic_data", 32'(io_deq_data), 32'h4321);
        check("basic_valid", 32'(io_deq_valid), 32'd1);
        step(1'b0, 4'h0, 1'b1);

        // Continuous streaming with no bubbles.
        do_reset();
        start = cyc;
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b1);
        step(1'b0, 4'h0, 1'b1);
        check("stream_words", 32'(got_words.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_words.size(); i++) begin
            logic [15:0] w;
            w = {4'(4 * i + 3), 4'(4 * i + 2), 4'(4 * i + 1), 4'(4 * i)};
            check("stream_word", 32'(got_words[i]), 32'(w));
            check("stream_cyc", got_cyc[i] - start, 32'(4 * (i + 1)));
        end

        // Backpressure holds the word and blocks enq.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'h9, 1'b0);
        check("hold_data", 32'(io_deq_data), 32'h4321);
        step(1'b1, 4'h9, 1'b1);
        check("hold_lane0", 32'(io_deq_data), 32'h0009);
        step(1'b0, 4'h0, 1'b1);

        // Reset mid-word discards the partial word.
        do_reset();
        step(1'b1, 4'hA, 1'b1);
        step(1'b1, 4'hB, 1'b1);
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1);
        check("rst_mid_count", 32'(got_words.size()), 32'd1);
        if (got_words.size() > 0) check("rst_mid_word", 32'(got_words[0]), 32'h4321);

`ifdef CH_PACKER_FLUSH_EN
        // Flush of a partial word, then flush at count 0.
        do_reset();
        step(1'b1, 4'h5, 1'b1);
        step(1'b1, 4'h6, 1'b0);
        io_flush = 1'b1;
        step(1'b0, 4'h0, 1'b0);
        io_flush = 1'b0;
        check("flush_data", 32'(io_deq_data), 32'h0065);
        check("flush_count", 32'(io_deq_count), 32'd2);
        step(1'b0, 4'h0, 1'b1);
        io_flush = 1'b1;
        step(1'b0, 4'h0, 1'b1);
        io_flush = 1'b0;
        check("flush_empty", 32'(io_deq_valid), 32'd0);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
`ifdef CH_PACKER_FLUSH_EN
            io_flush = ($urandom_range(0, 9) == 0);
`endif
            step(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 2) != 0));
        end
`ifdef CH_PACKER_FLUSH_EN
        io_flush = 1'b0;
`endif
        step(1'b0, 4'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
